k_bfly_stage: RTL and testbench



---
 rtl/k_fft_pkg.sv | 47 ++++
 rtl/k_bfly_addsub.sv | 36 +++
 rtl/k_fixedcmult.sv | 38 +++
 rtl/k_bfly_stage.sv | 100 ++++++++++
 tb/tb_k_bfly_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/k_fft_pkg.sv
// Shared FFT datapath types and helpers.
// Holds the Q(8-FRAC_BITS).FRAC_BITS complex sample format and the
// add/subtract primitive used by the butterfly.
package k_fft_pkg;

    localparam int unsigned FIX_W     = 8;
    localparam int unsigned FRAC_BITS = 4;
    localparam int unsigned CFIX_W    = 2 * FIX_W;

    // Complex sample, packed {im, re} to match the 16-bit bus layout.
    typedef struct packed {
        logic signed [FIX_W-1:0] im;
        logic signed [FIX_W-1:0] re;
    } cfix_t;

    // One component of an add/sub result plus its overflow indication.
    typedef struct packed {
        logic [FIX_W-1:0] val;
        logic             ovf;
    } addsub_res_t;

    // 9-bit sign-extended a +/- p; scale selects bits [8:1] (never overflows)
    // versus the wrapped low 8 bits with overflow when bit8 != bit7.
    function automatic addsub_res_t cfix_addsub(
        input logic signed [FIX_W-1:0] a,
        input logic signed [FIX_W-1:0] p,
        input logic                    sub,
        input logic                    scale
    );
        logic [FIX_W:0] s;
        addsub_res_t    r;
        if (sub) begin
            s = {a[FIX_W-1], a} - {p[FIX_W-1], p};
        end else begin
            s = {a[FIX_W-1], a} + {p[FIX_W-1], p};
        end
        if (scale) begin
            r.val = s[FIX_W:1];
            r.ovf = 1'b0;
        end else begin
            r.val = s[FIX_W-1:0];
            r.ovf = s[FIX_W] ^ s[FIX_W-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/k_bfly_addsub.sv
// Combinational butterfly core: x0 = a + p, x1 = a - p per component.
// Ports: i_a, i_p    complex operands {im, re}
//        o_x0_c      a + p
//        o_x1_c      a - p
//        o_ovf_c     any of the four component results wrapped (SCALE=0 only)
module k_bfly_addsub
    import k_fft_pkg::*;
#(
    parameter int unsigned SCALE = 0
) (
    input  logic [CFIX_W-1:0] i_a,
    input  logic [CFIX_W-1:0] i_p,
    output logic [CFIX_W-1:0] o_x0_c,
    output logic [CFIX_W-1:0] o_x1_c,
    output logic              o_ovf_c
);

    localparam logic L_SCALE = (SCALE != 0);

    cfix_t       w_a;
    cfix_t       w_p;
    addsub_res_t w_x0_re, w_x0_im, w_x1_re, w_x1_im;

    assign w_a = i_a;
    assign w_p = i_p;

    assign w_x0_re = cfix_addsub(w_a.re, w_p.re, 1'b0, L_SCALE);
    assign w_x0_im = cfix_addsub(w_a.im, w_p.im, 1'b0, L_SCALE);
    assign w_x1_re = cfix_addsub(w_a.re, w_p.re, 1'b1, L_SCALE);
    assign w_x1_im = cfix_addsub(w_a.im, w_p.im, 1'b1, L_SCALE);

    assign o_x0_c  = {w_x0_im.val, w_x0_re.val};
    assign o_x1_c  = {w_x1_im.val, w_x1_re.val};
    assign o_ovf_c = w_x0_re.ovf | w_x0_im.ovf | w_x1_re.ovf | w_x1_im.ovf;

endmodule

// File: rtl/k_fixedcmult.sv
// Combinational fixed-point complex multiplier p = x * y.
// Ports: i_x, i_y  complex operands {im, re}
//        o_p_c     product, arithmetic shift right by FRAC_BITS, truncated
//                  and wrapped to 8 bits per component
module k_fixedcmult
    import k_fft_pkg::*;
#(
    parameter int unsigned FRAC_BITS = k_fft_pkg::FRAC_BITS
) (
    input  logic [CFIX_W-1:0] i_x,
    input  logic [CFIX_W-1:0] i_y,
    output logic [CFIX_W-1:0] o_p_c
);

    localparam int unsigned MUL_W  = 2 * FIX_W;
    localparam int unsigned PROD_W = MUL_W + 1;

    cfix_t w_x;
    cfix_t w_y;
    logic signed [MUL_W-1:0]  w_rr, w_ii, w_ri, w_ir;
    logic signed [PROD_W-1:0] w_re_full, w_im_full;

    assign w_x = i_x;
    assign w_y = i_y;

    // Partial products at full precision.
    assign w_rr = MUL_W'($signed(w_x.re)) * MUL_W'($signed(w_y.re));
    assign w_ii = MUL_W'($signed(w_x.im)) * MUL_W'($signed(w_y.im));
    assign w_ri = MUL_W'($signed(w_x.re)) * MUL_W'($signed(w_y.im));
    assign w_ir = MUL_W'($signed(w_x.im)) * MUL_W'($signed(w_y.re));

    assign w_re_full = PROD_W'(w_rr) - PROD_W'(w_ii);
    assign w_im_full = PROD_W'(w_ri) + PROD_W'(w_ir);

    // Drop fractional bits (floor), keep the low 8 bits of the result.
    assign o_p_c = {FIX_W'(w_im_full >>> FRAC_BITS), FIX_W'(w_re_full >>> FRAC_BITS)};

endmodule

// File: rtl/k_bfly_stage.sv
// Two-stage pipelined radix-2 DIT butterfly with valid/ready handshake.
// Ports: clk, rst (async active-high)
//        in_valid/in_ready, in_a, in_b, in_w   input triple {im, re}
//        out_valid/out_ready, out_x0, out_x1   output pair a +/- w*b
//        ovf (sticky overflow), ovf_clr (synchronous clear, set wins)
module k_bfly_stage
    import k_fft_pkg::*;
#(
    parameter int unsigned SCALE     = 0,
    parameter int unsigned FRAC_BITS = k_fft_pkg::FRAC_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [15:0] in_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x0,
    output logic [15:0] out_x1,
    output logic        ovf,
    input  logic        ovf_clr
);

    logic              r_s1_valid, r_s2_valid, r_ovf;
    logic [CFIX_W-1:0] r_a, r_p, r_x0, r_x1;
    logic [CFIX_W-1:0] w_p, w_x0, w_x1;
    logic              w_ovf, w_adv1, w_adv2;

    // Twiddle product feeding S1.
    k_fixedcmult #(.FRAC_BITS(FRAC_BITS)) u_cmult (
        .i_x   (in_w),
        .i_y   (in_b),
        .o_p_c (w_p)
    );

    // Add/sub feeding S2.
    k_bfly_addsub #(.SCALE(SCALE)) u_addsub (
        .i_a     (r_a),
        .i_p     (r_p),
        .o_x0_c  (w_x0),
        .o_x1_c  (w_x1),
        .o_ovf_c (w_ovf)
    );

    // A stage advances when it is empty or its successor advances.
    assign w_adv2 = ~r_s2_valid | out_ready;
    assign w_adv1 = ~r_s1_valid | w_adv2;

    // Gate with rst so nothing is accepted while reset is held.
    assign in_ready  = w_adv1 & ~rst;
    assign out_valid = r_s2_valid;
    assign out_x0    = r_x0;
    assign out_x1    = r_x1;
    assign ovf       = r_ovf;

    // S1: sample a and twiddle product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_p        <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a <= in_a;
                r_p <= w_p;
            end
        end
    end

    // S2: butterfly outputs; a bubble from S1 clears s2_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_x0       <= '0;
            r_x1       <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_x0 <= w_x0;
                r_x1 <= w_x1;
            end
        end
    end

    // Sticky overflow; a new overflow in the same cycle beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv2 && r_s1_valid && w_ovf) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_k_bfly_stage.sv
module tb_k_bfly_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, ovf_clr;
    logic [15:0] in_a, in_b, in_w;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [15:0] x0_0, x1_0, x0_1, x1_1;

    always #5 clk = ~clk;

    // Same stimulus into an unscaled and a scaled instance.
    k_bfly_stage #(.SCALE(0)) dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_w(in_w),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_x0(x0_0), .out_x1(x1_0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    k_bfly_stage #(.SCALE(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_w(in_w),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_x0(x0_1), .out_x1(x1_1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic [15:0] x0s0;
        logic [15:0] x1s0;
        logic [15:0] x0s1;
        logic [15:0] x1s1;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: complex multiply with floor of the fractional bits.
    function automatic logic [15:0] ref_cmul(input logic [15:0] b, input logic [15:0] w);
        int br, bi, wr, wi, pr, pi;
        br = int'($signed(b[7:0]));
        bi = int'($signed(b[15:8]));
        wr = int'($signed(w[7:0]));
        wi = int'($signed(w[15:8]));
        pr = (wr * br - wi * bi) >>> 4;
        pi = (wr * bi + wi * br) >>> 4;
        return {8'(pi), 8'(pr)};
    endfunction

    function automatic logic [7:0] ref_comp(input logic [7:0] a, input logic [7:0] p,
                                            input bit sub, input bit scale);
        int ai, pi, s;
        ai = int'($signed(a));
        pi = int'($signed(p));
        s  = sub ? ai - pi : ai + pi;
        if (scale) return 8'(s >>> 1);
        return 8'(s);
    endfunction

    function automatic exp_t ref_exp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
        logic [15:0] p;
        exp_t        e;
        p = ref_cmul(b, w);
        e.x0s0 = {ref_comp(a[15:8], p[15:8], 0, 0), ref_comp(a[7:0], p[7:0], 0, 0)};
        e.x1s0 = {ref_comp(a[15:8], p[15:8], 1, 0), ref_comp(a[7:0], p[7:0], 1, 0)};
        e.x0s1 = {ref_comp(a[15:8], p[15:8], 0, 1), ref_comp(a[7:0], p[7:0], 0, 1)};
        e.x1s1 = {ref_comp(a[15:8], p[15:8], 1, 1), ref_comp(a[7:0], p[7:0], 1, 1)};
        return e;
    endfunction

    // Present a triple, hold until accepted, then push its expected pair.
    task automatic send_exp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w, input exp_t e);
        bit ok;
        in_a = a; in_b = b; in_w = w; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 16'(ok), 16'd1);
        else begin
            sb.push_back(e);
            n_vec++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
        send_exp(a, b, w, ref_exp(a, b, w));
    endtask

    task automatic mk(output exp_t e, input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1);
        e.x0s0 = a0; e.x1s0 = b0; e.x0s1 = a1; e.x1s1 = b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_left", 16'(sb.size()), 16'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Monitor: pop/compare on each output transfer, check stall stability.
    initial begin : monitor
        logic        prev_stall;
        logic [15:0] px0, px1;
        exp_t        e;
        prev_stall = 1'b0;
        px0 = '0; px1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 16'(out_valid0), 16'd1);
                    chk("stall_x0", x0_0, px0);
                    chk("stall_x1", x1_0, px1);
                end
                if (out_valid0 !== out_valid1 || in_ready0 !== in_ready1)
                    chk("twin_handshake", {out_valid1, in_ready1}, {out_valid0, in_ready0});
                if (out_valid0 && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 16'(out_valid0), 16'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("x0_s0", x0_0, e.x0s0);
                        chk("x1_s0", x1_0, e.x1s0);
                        chk("x0_s1", x0_1, e.x0s1);
                        chk("x1_s1", x1_1, e.x1s1);
                        chk("ovf_s1", 16'(ovf1), 16'd0);
                    end
                end
                prev_stall = out_valid0 && !out_ready;
                px0 = x0_0;
                px1 = x1_0;
            end
        end
    end

    initial begin : stim
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        in_a = '0; in_b = '0; in_w = '0;
        #2;
        chk("rst_out_valid", 16'(out_valid0), 16'd0);
        chk("rst_in_ready", 16'(in_ready0), 16'd0);
        chk("rst_x0", x0_0, 16'h0000);
        chk("rst_x1", x1_0, 16'h0000);
        chk("rst_ovf", 16'(ovf0), 16'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic and w=j vectors.
        mk(e, 16'h0020, 16'h0000, 16'h0010, 16'h0000);
        send_exp(16'h0010, 16'h0010, 16'h0010, e);
        mk(e, 16'h1010, 16'hF010, 16'h0808, 16'hF808);
        send_exp(16'h0010, 16'h0010, 16'h1000, e);
        drain();
        chk("ovf_clean", 16'(ovf0), 16'd0);

        // Positive wrap sets ovf; ovf_clr clears it.
        mk(e, 16'h0090, 16'h0050, 16'h0048, 16'h0028);
        send_exp(16'h0070, 16'h0020, 16'h0010, e);
        drain();
        chk("ovf_set", 16'(ovf0), 16'd1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", 16'(ovf0), 16'd0);

        // Negative wrap on the difference.
        mk(e, 16'h0090, 16'h0070, 16'h00C8, 16'h00B8);
        send_exp(16'h0080, 16'h0010, 16'h0010, e);
        drain();
        chk("ovf_neg", 16'(ovf0), 16'd1);

        // Product truncation toward minus infinity.
        mk(e, 16'h0001, 16'h00FF, 16'h0000, 16'h00FF);
        send_exp(16'h0000, 16'h0003, 16'h0008, e);
        mk(e, 16'h00FE, 16'h0002, 16'h00FF, 16'h0001);
        send_exp(16'h0000, 16'h00FD, 16'h0008, e);
        drain();

        // Fill with out_ready low: only two accepts, then in-order drain.
        out_ready = 1'b0;
        begin
            int base;
            base = n_vec;
            fork
                begin
                    for (int i = 0; i < 8; i++)
                        send(16'((i * 16'h0913) ^ 16'h2405), 16'(16'h1107 * (i + 1)), 16'h0C0B - 16'(i));
                end
                begin
                    repeat (6) @(posedge clk);
                    #2;
                    chk("fill_accepts", 16'(n_vec - base), 16'd2);
                    chk("fill_in_ready", 16'(in_ready0), 16'd0);
                    out_ready = 1'b1;
                end
            join
        end
        drain();

        // Random valid gaps and ready toggling.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(16'($urandom), 16'($urandom), 16'($urandom));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two pairs in flight discards them.
        out_ready = 1'b0;
        send(16'h1234, 16'h0F0F, 16'h0010);
        send(16'h4321, 16'h0101, 16'h1000);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 16'(out_valid0), 16'd0);
        chk("midrst_in_ready", 16'(in_ready0), 16'd0);
        chk("midrst_x0", x0_0, 16'h0000);
        chk("midrst_x1", x1_0, 16'h0000);
        chk("midrst_ovf", 16'(ovf0), 16'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        mk(e, 16'h0020, 16'h0000, 16'h0010, 16'h0000);
        send_exp(16'h0010, 16'h0010, 16'h0010, e);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
